tx_frame_arbiter: RTL and testbench

//  Shares the single byte-serial transmitter (tx_module) between N_REQ byte-stream

---
 rtl/tx_arb_pkg.sv | 16 +
 rtl/tx_frame_arbiter_rr_pick.sv | 34 +++
 rtl/tx_frame_arbiter.sv | 174 +++++++++++++++++
 tb/tb_tx_frame_arbiter.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_arb_pkg.sv
// Shared types and constants for the tx_frame_arbiter slice.
// FRAME_TAG_EN (optional macro) enables the per-frame tag byte state.
package tx_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TAG,
    ST_LOAD,
    ST_HOLD,
    ST_GAP
  } arbState_t;

  localparam logic [7:0] TAG_BASE  = 8'hA0;
  localparam logic [7:0] ABORT_MAX = 8'd255;

endpackage

// File: rtl/tx_frame_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first valid requester at or
// after the pointer, wrapping modulo N_REQ.
module rr_pick
  import tx_arb_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0] valid_i,
  input  logic [2:0]       ptr_i,
  output logic [2:0]       grant_o,
  output logic             any_o
);

  logic [7:0] validPad;
  logic [3:0] cand;

  assign validPad = 8'(valid_i);

  // Scan from the farthest offset down so the nearest valid requester wins.
  always_comb begin
    grant_o = '0;
    any_o   = 1'b0;
    cand    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr_i} + 4'(k);
      if (cand >= 4'(N_REQ)) cand = cand - 4'(N_REQ);
      if (validPad[cand[2:0]]) begin
        grant_o = cand[2:0];
        any_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_frame_arbiter.sv
// Frame-level round-robin arbiter feeding a byte-serial transmitter.
// Define FRAME_TAG_EN to send an 8'hA0|grant tag byte ahead of each frame.
module tx_frame_arbiter
  import tx_arb_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int GAP_CYCLES = 2000,
  parameter int TIMEOUT    = 4095
) (
  input  logic                 M_AXIS_Clk,
  input  logic                 M_AXIS_nRst,
  input  logic [N_REQ-1:0]     req_tvalid,
  input  logic [8*N_REQ-1:0]   req_tdata,
  input  logic [N_REQ-1:0]     req_tlast,
  output logic [N_REQ-1:0]     req_tready,
  input  logic                 tx_done,
  output logic [7:0]           tx_data,
  output logic                 send_sig,
  output logic [2:0]           grant_id,
  output logic                 busy,
  output logic [7:0]           abort_cnt
);

  localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  arbState_t        state_q, state_d;
  logic [2:0]       grant_q, grant_d;
  logic [2:0]       ptr_q, ptr_d;
  logic             busy_q, busy_d;
  logic             sendSig_q, sendSig_d;
  logic             lastR_q, lastR_d;
  logic [7:0]       txData_q, txData_d;
  logic [7:0]       abortCnt_q, abortCnt_d;
  logic [TO_W-1:0]  toCnt_q, toCnt_d;
  logic [GAP_W-1:0] gapCnt_q, gapCnt_d;

  logic [2:0]       pickIdx;
  logic             pickAny;
  logic [7:0]       validPad;
  logic [7:0]       lastPad;
  logic [63:0]      dataPad;
  logic             transfer;
  logic [2:0]       ptrNext;
  logic [TO_W-1:0]  toNext;
  logic             gapDone;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .valid_i (req_tvalid),
    .ptr_i   (ptr_q),
    .grant_o (pickIdx),
    .any_o   (pickAny)
  );

  assign validPad = 8'(req_tvalid);
  assign lastPad  = 8'(req_tlast);
  assign dataPad  = 64'(req_tdata);
  assign transfer = (state_q == ST_LOAD) && tx_done && validPad[grant_q];
  assign ptrNext  = (grant_q == 3'(N_REQ - 1)) ? 3'd0 : grant_q + 3'd1;
  assign toNext   = toCnt_q + TO_W'(1);
  assign gapDone  = (GAP_CYCLES <= 1) ? 1'b1 : (gapCnt_q == GAP_W'(GAP_CYCLES - 1));

  // The accept strobe is only ever the single granted bit, on the transfer cycle.
  assign req_tready = transfer ? N_REQ'(8'b1 << grant_q) : '0;

  assign tx_data   = txData_q;
  assign send_sig  = sendSig_q;
  assign grant_id  = grant_q;
  assign busy      = busy_q;
  assign abort_cnt = abortCnt_q;

  always_ff @(posedge M_AXIS_Clk or negedge M_AXIS_nRst) begin
    if (!M_AXIS_nRst) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      ptr_q      <= '0;
      busy_q     <= 1'b0;
      sendSig_q  <= 1'b0;
      lastR_q    <= 1'b0;
      txData_q   <= '0;
      abortCnt_q <= '0;
      toCnt_q    <= '0;
      gapCnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      busy_q     <= busy_d;
      sendSig_q  <= sendSig_d;
      lastR_q    <= lastR_d;
      txData_q   <= txData_d;
      abortCnt_q <= abortCnt_d;
      toCnt_q    <= toCnt_d;
      gapCnt_q   <= gapCnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    busy_d     = busy_q;
    sendSig_d  = sendSig_q;
    lastR_d    = lastR_q;
    txData_d   = txData_q;
    abortCnt_d = abortCnt_q;
    toCnt_d    = toCnt_q;
    gapCnt_d   = gapCnt_q;

    case (state_q)
      ST_IDLE: begin
        if (pickAny) begin
          grant_d = pickIdx;
          busy_d  = 1'b1;
          toCnt_d = '0;
`ifdef FRAME_TAG_EN
          state_d = ST_TAG;
`else
          state_d = ST_LOAD;
`endif
        end
      end
`ifdef FRAME_TAG_EN
      ST_TAG: begin
        if (tx_done) begin
          txData_d  = TAG_BASE | {5'd0, grant_q};
          sendSig_d = 1'b1;
          lastR_d   = 1'b0;
          state_d   = ST_HOLD;
        end
      end
`endif
      ST_LOAD: begin
        if (transfer) begin
          txData_d  = dataPad[{grant_q, 3'b000} +: 8];
          sendSig_d = 1'b1;
          lastR_d   = lastPad[grant_q];
          toCnt_d   = '0;
          state_d   = ST_HOLD;
        end else if (toNext == TO_W'(TIMEOUT)) begin
          // Abandon the stalled frame; advancing the pointer keeps others from starving.
          abortCnt_d = (abortCnt_q == ABORT_MAX) ? abortCnt_q : abortCnt_q + 8'd1;
          toCnt_d    = '0;
          ptr_d      = ptrNext;
          gapCnt_d   = '0;
          state_d    = ST_GAP;
        end else begin
          toCnt_d = toNext;
        end
      end
      ST_HOLD: begin
        sendSig_d = 1'b0;
        if (lastR_q) begin
          ptr_d    = ptrNext;
          gapCnt_d = '0;
          state_d  = ST_GAP;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_GAP: begin
        if (gapDone) begin
          busy_d   = 1'b0;
          gapCnt_d = '0;
          state_d  = ST_IDLE;
        end else begin
          gapCnt_d = gapCnt_q + GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Directed bench for tx_frame_arbiter with a 10-clock serializer model.
// Expectations follow FRAME_TAG_EN when the bench is built with it.
module tb_tx_frame_arbiter;

  localparam int GAP_CYCLES = 2000;
  localparam int TIMEOUT    = 4095;
  localparam int TX_BUSY    = 10;
`ifdef FRAME_TAG_EN
  localparam logic [7:0] GAP0_NEXT = 8'hA1;
`else
  localparam logic [7:0] GAP0_NEXT = 8'hC1;
`endif

  logic clock = 1'b0;
  logic nRst  = 1'b0;
  always #5 clock = ~clock;

  logic [1:0]  reqTvalid, reqTlast, reqTready;
  logic [15:0] reqTdata;
  logic        txDone;
  logic [7:0]  txData;
  logic        sendSig;
  logic [2:0]  grantId;
  logic        busy;
  logic [7:0]  abortCnt;

  logic [1:0]  bTvalid, bTlast, bTready;
  logic [15:0] bTdata;
  logic        bTxDone;
  logic [7:0]  bTxData;
  logic        bSendSig;
  logic [2:0]  bGrantId;
  logic        bBusy;
  logic [7:0]  bAbortCnt;

  logic [8:0]  q0[$];
  logic [8:0]  q1[$];
  logic [10:0] capQ[$];
  logic [10:0] expQ[$];

  int vecs = 0;
  int miss = 0;
  int protoErr = 0;
  int pulseErr = 0;

  tx_frame_arbiter #(.N_REQ(2), .GAP_CYCLES(GAP_CYCLES), .TIMEOUT(TIMEOUT)) dut (
    .M_AXIS_Clk (clock),     .M_AXIS_nRst (nRst),
    .req_tvalid (reqTvalid), .req_tdata   (reqTdata),
    .req_tlast  (reqTlast),  .req_tready  (reqTready),
    .tx_done    (txDone),    .tx_data     (txData),
    .send_sig   (sendSig),   .grant_id    (grantId),
    .busy       (busy),      .abort_cnt   (abortCnt)
  );

  tx_frame_arbiter #(.N_REQ(2), .GAP_CYCLES(0), .TIMEOUT(TIMEOUT)) dutGap0 (
    .M_AXIS_Clk (clock),    .M_AXIS_nRst (nRst),
    .req_tvalid (bTvalid),  .req_tdata   (bTdata),
    .req_tlast  (bTlast),   .req_tready  (bTready),
    .tx_done    (bTxDone),  .tx_data     (bTxData),
    .send_sig   (bSendSig), .grant_id    (bGrantId),
    .busy       (bBusy),    .abort_cnt   (bAbortCnt)
  );

  task automatic driveReq();
    reqTvalid[0]   = (q0.size() > 0);
    reqTdata[7:0]  = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
    reqTlast[0]    = (q0.size() > 0) ? q0[0][8] : 1'b0;
    reqTvalid[1]   = (q1.size() > 0);
    reqTdata[15:8] = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
    reqTlast[1]    = (q1.size() > 0) ? q1[0][8] : 1'b0;
  endtask

  // Requesters pop a byte once its handshake has been seen mid-cycle.
  initial begin
    logic [1:0] hs;
    forever begin
      @(negedge clock);
      hs = reqTvalid & reqTready;
      @(posedge clock);
      #1;
      if (hs[0] && q0.size() > 0) void'(q0.pop_front());
      if (hs[1] && q1.size() > 0) void'(q1.pop_front());
      driveReq();
    end
  end

  // Serializer: captures each started byte and stays busy for TX_BUSY clocks.
  initial begin
    int  cnt;
    logic prevSend;
    cnt = 0;
    prevSend = 1'b0;
    txDone = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      if (!nRst) begin
        txDone = 1'b1;
        cnt = 0;
        prevSend = 1'b0;
      end else begin
        if (sendSig) begin
          capQ.push_back({grantId, txData});
          if (prevSend) pulseErr++;
          txDone = 1'b0;
          cnt = TX_BUSY;
        end else if (cnt > 0) begin
          cnt--;
          if (cnt == 0) txDone = 1'b1;
        end
        prevSend = sendSig;
      end
    end
  end

  always @(negedge clock) begin
    if (nRst) begin
      if (reqTready != 2'b00 && reqTready != (2'(1) << grantId)) protoErr++;
      if (bTready != 2'b00 && bTready != (2'(1) << bGrantId)) protoErr++;
    end
  end

  task automatic expByte(input logic [2:0] g, input logic [7:0] d);
    expQ.push_back({g, d});
  endtask

  task automatic expTag(input logic [2:0] g);
`ifdef FRAME_TAG_EN
    expQ.push_back({g, 8'hA0 | {5'd0, g}});
`endif
  endtask

  task automatic doReset();
    nRst = 1'b0;
    q0.delete();
    q1.delete();
    driveReq();
    capQ.delete();
    expQ.delete();
    bTvalid = 2'b00;
    bTlast  = 2'b00;
    bTdata  = 16'h0000;
    bTxDone = 1'b1;
    repeat (3) @(posedge clock);
    #2;
    nRst = 1'b1;
    @(posedge clock);
    #2;
  endtask

  task automatic waitCap(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (capQ.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(posedge clock);
      #2;
    end
  endtask

  task automatic waitIdle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      @(posedge clock);
      #2;
    end
  endtask

  task automatic test_reset();
    nRst = 1'b0;
    bTvalid = 2'b00; bTlast = 2'b00; bTdata = 16'h0000; bTxDone = 1'b1;
    driveReq();
    repeat (2) @(posedge clock);
    #2;
    vecs++; if (sendSig !== 1'b0) begin miss++; $display("[TB] FAIL reset_send_sig: got %b expected 0", sendSig); end
    vecs++; if (txData !== 8'h00) begin miss++; $display("[TB] FAIL reset_tx_data: got %h expected 00", txData); end
    vecs++; if (busy !== 1'b0) begin miss++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    vecs++; if (grantId !== 3'd0) begin miss++; $display("[TB] FAIL reset_grant_id: got %0d expected 0", grantId); end
    vecs++; if (abortCnt !== 8'd0) begin miss++; $display("[TB] FAIL reset_abort_cnt: got %0d expected 0", abortCnt); end
    vecs++; if (reqTready !== 2'b00) begin miss++; $display("[TB] FAIL reset_tready: got %b expected 00", reqTready); end
    nRst = 1'b1;
    repeat (5) @(posedge clock);
    #2;
    vecs++; if (busy !== 1'b0 || sendSig !== 1'b0) begin miss++; $display("[TB] FAIL reset_idle: busy %b send %b expected 0 0", busy, sendSig); end
  endtask

  task automatic test_single_frame();
    bit ok;
    int n;
    doReset();
    q0.push_back({1'b0, 8'h11});
    q0.push_back({1'b0, 8'h22});
    q0.push_back({1'b1, 8'h33});
    driveReq();
    expTag(3'd0);
    expByte(3'd0, 8'h11);
    expByte(3'd0, 8'h22);
    expByte(3'd0, 8'h33);
    waitCap(expQ.size(), 500, ok);
    vecs++; if (!ok) begin miss++; $display("[TB] FAIL single_wait: got %0d bytes expected %0d", capQ.size(), expQ.size()); end
    vecs++; if (busy !== 1'b1) begin miss++; $display("[TB] FAIL single_busy: got %b expected 1", busy); end
    n = 0;
    while (busy && n < GAP_CYCLES + 100) begin
      @(posedge clock);
      #2;
      n++;
    end
    vecs++; if (n != GAP_CYCLES + 1) begin miss++; $display("[TB] FAIL single_gap_len: got %0d clocks expected %0d", n, GAP_CYCLES + 1); end
    vecs++; if (capQ.size() != expQ.size()) begin miss++; $display("[TB] FAIL single_count: got %0d expected %0d", capQ.size(), expQ.size()); end
    for (int k = 0; k < expQ.size() && k < capQ.size(); k++) begin
      vecs++;
      if (capQ[k] !== expQ[k]) begin
        miss++;
        $display("[TB] FAIL single_byte%0d: got g%0d/%h expected g%0d/%h", k, capQ[k][10:8], capQ[k][7:0], expQ[k][10:8], expQ[k][7:0]);
      end
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    doReset();
    q0.push_back({1'b0, 8'h41});
    q0.push_back({1'b1, 8'h42});
    q1.push_back({1'b1, 8'h51});
    driveReq();
    expTag(3'd0); expByte(3'd0, 8'h41); expByte(3'd0, 8'h42);
    expTag(3'd1); expByte(3'd1, 8'h51);
    waitCap(expQ.size(), 6000, ok);
    waitIdle(3000, ok);
    vecs++; if (!ok) begin miss++; $display("[TB] FAIL rr_idle1: busy %b expected 0", busy); end
    q0.push_back({1'b1, 8'h43});
    driveReq();
    expTag(3'd0); expByte(3'd0, 8'h43);
    waitCap(expQ.size(), 500, ok);
    waitIdle(3000, ok);
    q0.push_back({1'b1, 8'h44});
    q1.push_back({1'b1, 8'h52});
    driveReq();
    expTag(3'd1); expByte(3'd1, 8'h52);
    expTag(3'd0); expByte(3'd0, 8'h44);
    waitCap(expQ.size(), 6000, ok);
    vecs++; if (capQ.size() != expQ.size()) begin miss++; $display("[TB] FAIL rr_count: got %0d expected %0d", capQ.size(), expQ.size()); end
    for (int k = 0; k < expQ.size() && k < capQ.size(); k++) begin
      vecs++;
      if (capQ[k] !== expQ[k]) begin
        miss++;
        $display("[TB] FAIL rr_byte%0d: got g%0d/%h expected g%0d/%h", k, capQ[k][10:8], capQ[k][7:0], expQ[k][10:8], expQ[k][7:0]);
      end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int stray;
    doReset();
    q1.push_back({1'b0, 8'h61});
    driveReq();
    expTag(3'd1); expByte(3'd1, 8'h61);
    waitCap(expQ.size(), 500, ok);
    vecs++; if (!ok) begin miss++; $display("[TB] FAIL to_first: got %0d bytes expected %0d", capQ.size(), expQ.size()); end
    repeat (TIMEOUT - 5) @(posedge clock);
    #2;
    vecs++; if (abortCnt !== 8'd0) begin miss++; $display("[TB] FAIL to_early: got %0d expected 0", abortCnt); end
    repeat (10) @(posedge clock);
    #2;
    vecs++; if (abortCnt !== 8'd1) begin miss++; $display("[TB] FAIL to_abort: got %0d expected 1", abortCnt); end
    q0.push_back({1'b1, 8'h71});
    q1.push_back({1'b1, 8'h63});
    driveReq();
    stray = 0;
    ok = 1'b0;
    for (int i = 0; i < GAP_CYCLES + 100; i++) begin
      @(negedge clock);
      if (reqTready[1]) stray++;
      if (grantId == 3'd0) begin
        ok = 1'b1;
        break;
      end
    end
    vecs++; if (!ok) begin miss++; $display("[TB] FAIL to_regrant: got grant %0d expected 0", grantId); end
    vecs++; if (stray != 0) begin miss++; $display("[TB] FAIL to_stray_ready: got %0d accepts expected 0", stray); end
    expTag(3'd0); expByte(3'd0, 8'h71);
    expTag(3'd1); expByte(3'd1, 8'h63);
    waitCap(expQ.size(), 3000, ok);
    vecs++; if (capQ.size() != expQ.size()) begin miss++; $display("[TB] FAIL to_count: got %0d expected %0d", capQ.size(), expQ.size()); end
    for (int k = 0; k < expQ.size() && k < capQ.size(); k++) begin
      vecs++;
      if (capQ[k] !== expQ[k]) begin
        miss++;
        $display("[TB] FAIL to_byte%0d: got g%0d/%h expected g%0d/%h", k, capQ[k][10:8], capQ[k][7:0], expQ[k][10:8], expQ[k][7:0]);
      end
    end
  endtask

  task automatic test_tag();
    bit ok;
    doReset();
    q1.push_back({1'b1, 8'h5A});
    driveReq();
    expTag(3'd1); expByte(3'd1, 8'h5A);
    waitCap(expQ.size(), 500, ok);
    repeat (30) @(posedge clock);
    #2;
    vecs++; if (capQ.size() != expQ.size()) begin miss++; $display("[TB] FAIL tag_count: got %0d expected %0d", capQ.size(), expQ.size()); end
    for (int k = 0; k < expQ.size() && k < capQ.size(); k++) begin
      vecs++;
      if (capQ[k] !== expQ[k]) begin
        miss++;
        $display("[TB] FAIL tag_byte%0d: got g%0d/%h expected g%0d/%h", k, capQ[k][10:8], capQ[k][7:0], expQ[k][10:8], expQ[k][7:0]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    doReset();
    q0.push_back({1'b1, 8'h80});
    driveReq();
    expTag(3'd0); expByte(3'd0, 8'h80);
    waitCap(expQ.size(), 500, ok);
    waitIdle(3000, ok);
    q1.push_back({1'b0, 8'h81});
    q1.push_back({1'b0, 8'h82});
    q1.push_back({1'b1, 8'h83});
    driveReq();
    expTag(3'd1); expByte(3'd1, 8'h81); expByte(3'd1, 8'h82);
    waitCap(expQ.size(), 500, ok);
    vecs++; if (sendSig !== 1'b1 || txData !== 8'h82) begin miss++; $display("[TB] FAIL mid_pre: got send %b data %h expected 1 82", sendSig, txData); end
    nRst = 1'b0;
    #1;
    vecs++; if (sendSig !== 1'b0) begin miss++; $display("[TB] FAIL mid_send_sig: got %b expected 0", sendSig); end
    vecs++; if (reqTready !== 2'b00) begin miss++; $display("[TB] FAIL mid_tready: got %b expected 00", reqTready); end
    vecs++; if (busy !== 1'b0) begin miss++; $display("[TB] FAIL mid_busy: got %b expected 0", busy); end
    vecs++; if (txData !== 8'h00) begin miss++; $display("[TB] FAIL mid_tx_data: got %h expected 00", txData); end
    doReset();
    q0.push_back({1'b1, 8'h91});
    q1.push_back({1'b1, 8'h92});
    driveReq();
    expTag(3'd0); expByte(3'd0, 8'h91);
    waitCap(expQ.size(), 500, ok);
    vecs++; if (capQ.size() < expQ.size()) begin miss++; $display("[TB] FAIL mid_regrant_count: got %0d expected %0d", capQ.size(), expQ.size()); end
    for (int k = 0; k < expQ.size() && k < capQ.size(); k++) begin
      vecs++;
      if (capQ[k] !== expQ[k]) begin
        miss++;
        $display("[TB] FAIL mid_regrant%0d: got g%0d/%h expected g%0d/%h", k, capQ[k][10:8], capQ[k][7:0], expQ[k][10:8], expQ[k][7:0]);
      end
    end
  endtask

  task automatic test_back_to_back_gap0();
    int c0Cyc;
    int nextCyc;
    int lowCnt;
    logic [7:0] nextData;
    doReset();
    c0Cyc = -1;
    nextCyc = -1;
    lowCnt = 0;
    nextData = 8'h00;
    bTdata  = {8'hC1, 8'hC0};
    bTlast  = 2'b11;
    bTvalid = 2'b11;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #2;
      if (bSendSig) begin
        if (c0Cyc >= 0 && nextCyc < 0) begin
          nextCyc = i;
          nextData = bTxData;
        end
        if (bTxData == 8'hC0) begin
          bTvalid[0] = 1'b0;
          c0Cyc = i;
        end else if (bTxData == 8'hC1) begin
          bTvalid[1] = 1'b0;
        end
      end else if (c0Cyc >= 0 && nextCyc < 0 && !bBusy) begin
        lowCnt++;
      end
    end
    vecs++; if (c0Cyc < 0 || nextCyc < 0) begin miss++; $display("[TB] FAIL gap0_pulses: got c0 at %0d next at %0d expected both seen", c0Cyc, nextCyc); end
    vecs++; if (nextCyc - c0Cyc != 4) begin miss++; $display("[TB] FAIL gap0_spacing: got %0d clocks expected 4", nextCyc - c0Cyc); end
    vecs++; if (nextData !== GAP0_NEXT) begin miss++; $display("[TB] FAIL gap0_next_byte: got %h expected %h", nextData, GAP0_NEXT); end
    vecs++; if (lowCnt != 1) begin miss++; $display("[TB] FAIL gap0_idle_clocks: got %0d expected 1", lowCnt); end
  endtask

  task automatic test_protocol();
    vecs++; if (protoErr != 0) begin miss++; $display("[TB] FAIL proto_tready: got %0d violations expected 0", protoErr); end
    vecs++; if (pulseErr != 0) begin miss++; $display("[TB] FAIL proto_pulse: got %0d long pulses expected 0", pulseErr); end
  endtask

  initial begin
    q0.delete();
    q1.delete();
    driveReq();
    test_reset();
    test_single_frame();
    test_round_robin();
    test_timeout();
    test_tag();
    test_reset_mid_frame();
    test_back_to_back_gap0();
    test_protocol();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
